// File: rtl/sobel_pkg.sv
// sobel_pkg: shared definitions for the Sobel edge statistics slice.
//   - default frame geometry and datapath widths
//   - coordinate width and the "empty bounding box" sentinel
//   - FSM state encoding for frame tracking
package sobel_pkg;

  localparam int DEF_COLNUM = 1920;  // active columns
  localparam int DEF_ROWNUM = 1080;  // active rows
  localparam int DEF_MAG_W  = 11;    // gradient magnitude / threshold width
  localparam int DEF_CNT_W  = 22;    // edge counter width, holds COLNUM*ROWNUM

  localparam int COORD_W = 12;

  // Min registers start here so the first edge always wins the compare.
  localparam logic [COORD_W-1:0] BBOX_EMPTY = 12'hFFF;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

endpackage

// File: rtl/sobel_edge_stats_if.sv
// sobel_edge_stats_if: frame-statistics result port (valid/ready).
//   stat_valid     result available (producer -> consumer)
//   stat_ready     consumer accepts the result
//   stat_edge_cnt  edge pixels in the frame
//   stat_x_min/x_max/y_min/y_max  edge bounding box
//   stat_overrun   previous result was overwritten before being read
// master = statistics producer, slave = control/readout consumer.
interface sobel_edge_stats_if
  import sobel_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
);

  logic               stat_valid;
  logic               stat_ready;
  logic [CNT_W-1:0]   stat_edge_cnt;
  logic [COORD_W-1:0] stat_x_min;
  logic [COORD_W-1:0] stat_x_max;
  logic [COORD_W-1:0] stat_y_min;
  logic [COORD_W-1:0] stat_y_max;
  logic               stat_overrun;

  modport master (
    output stat_valid, stat_edge_cnt, stat_x_min, stat_x_max,
           stat_y_min, stat_y_max, stat_overrun,
    input  stat_ready
  );

  modport slave (
    input  stat_valid, stat_edge_cnt, stat_x_min, stat_x_max,
           stat_y_min, stat_y_max, stat_overrun,
    output stat_ready
  );

endinterface

// File: rtl/sobel_bbox_acc.sv
// sobel_bbox_acc: per-frame edge count and bounding-box accumulator.
//   clk, rst_n  clock / asynchronous active-low reset
//   clr         restart accumulation (empty box, zero count)
//   upd         apply an edge at (x, y); combines with clr as "clear, then apply"
//   x, y        edge coordinate
//   *_nxt       accumulator contents including this cycle's clr/upd, so the
//               caller can capture a final result in the same cycle as the
//               last update
module sobel_bbox_acc
  import sobel_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               upd,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  output logic [CNT_W-1:0]   cnt_nxt,
  output logic [COORD_W-1:0] x_min_nxt,
  output logic [COORD_W-1:0] x_max_nxt,
  output logic [COORD_W-1:0] y_min_nxt,
  output logic [COORD_W-1:0] y_max_nxt
);

  logic [CNT_W-1:0]   cnt_reg;
  logic [COORD_W-1:0] x_min_reg, x_max_reg, y_min_reg, y_max_reg;

  // Starting point for this cycle: either the running values or an empty box.
  logic [CNT_W-1:0]   cnt_base;
  logic [COORD_W-1:0] x_min_base, x_max_base, y_min_base, y_max_base;

  always_comb begin
    cnt_base   = clr ? '0         : cnt_reg;
    x_min_base = clr ? BBOX_EMPTY : x_min_reg;
    x_max_base = clr ? '0         : x_max_reg;
    y_min_base = clr ? BBOX_EMPTY : y_min_reg;
    y_max_base = clr ? '0         : y_max_reg;

    cnt_nxt   = cnt_base;
    x_min_nxt = x_min_base;
    x_max_nxt = x_max_base;
    y_min_nxt = y_min_base;
    y_max_nxt = y_max_base;

    if (upd) begin
      // Saturate rather than wrap so a huge frame never reports a small count.
      if (cnt_base != '1) cnt_nxt = cnt_base + CNT_W'(1);
      if (x < x_min_base) x_min_nxt = x;
      if (x > x_max_base) x_max_nxt = x;
      if (y < y_min_base) y_min_nxt = y;
      if (y > y_max_base) y_max_nxt = y;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg   <= '0;
      x_min_reg <= BBOX_EMPTY;
      x_max_reg <= '0;
      y_min_reg <= BBOX_EMPTY;
      y_max_reg <= '0;
    end else begin
      cnt_reg   <= cnt_nxt;
      x_min_reg <= x_min_nxt;
      x_max_reg <= x_max_nxt;
      y_min_reg <= y_min_nxt;
      y_max_reg <= y_max_nxt;
    end
  end

endmodule

// File: rtl/sobel_edge_stats.sv
// sobel_edge_stats: thresholds the Sobel gradient into a binary edge stream
// and publishes per-frame edge statistics at end of frame.
//   clk, rst_n              clock / asynchronous active-low reset
//   in_valid, pos_valid     beat strobe and "inside active frame" flag
//   a22_x, a22_y            corrected pixel position
//   grad_mag, threshold     gradient magnitude and edge threshold
//   edge_valid/bit/x/y      registered edge stream (1-cycle latency)
//   stat                    frame result port (valid/ready, master side)
// Frame tracking only starts on the origin beat (0,0), so a reset mid-frame
// stays silent until the next frame begins.
module sobel_edge_stats
  import sobel_pkg::*;
#(
  parameter int RAW_FRAME_COLNUM = DEF_COLNUM,
  parameter int RAW_FRAME_ROWNUM = DEF_ROWNUM,
  parameter int MAG_W            = DEF_MAG_W,
  parameter int CNT_W            = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic               pos_valid,
  input  logic [COORD_W-1:0] a22_x,
  input  logic [COORD_W-1:0] a22_y,
  input  logic [MAG_W-1:0]   grad_mag,
  input  logic [MAG_W-1:0]   threshold,
  output logic               edge_valid,
  output logic               edge_bit,
  output logic [COORD_W-1:0] edge_x,
  output logic [COORD_W-1:0] edge_y,
  sobel_edge_stats_if.master stat
);

  localparam logic [COORD_W-1:0] LAST_X = COORD_W'(RAW_FRAME_COLNUM - 1);
  localparam logic [COORD_W-1:0] LAST_Y = COORD_W'(RAW_FRAME_ROWNUM - 1);

  state_t           state_reg, state_next;
  logic [MAG_W-1:0] thr_reg;

  logic             qbeat, origin, last_beat, process, is_edge, frame_done;
  logic [MAG_W-1:0] thr_eff;

  logic [CNT_W-1:0]   acc_cnt;
  logic [COORD_W-1:0] acc_x_min, acc_x_max, acc_y_min, acc_y_max;

  always_comb begin
    qbeat     = in_valid && pos_valid;
    origin    = qbeat && (a22_x == '0) && (a22_y == '0);
    last_beat = qbeat && (a22_x == LAST_X) && (a22_y == LAST_Y);
    // In IDLE only the origin beat gets through; in ACCUM every qualified beat.
    process   = origin || ((state_reg == ACCUM) && qbeat);
    // The origin beat has to be judged against the threshold being latched
    // on this very cycle, not the previous frame's.
    thr_eff   = origin ? threshold : thr_reg;
    is_edge   = grad_mag >= thr_eff;
    frame_done = process && last_beat;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    if (frame_done)  state_next = IDLE;
    else if (origin) state_next = ACCUM;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      thr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (origin) thr_reg <= threshold;
    end
  end

  // Edge stream: data registers only move on processed beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_valid <= 1'b0;
      edge_bit   <= 1'b0;
      edge_x     <= '0;
      edge_y     <= '0;
    end else begin
      edge_valid <= process;
      if (process) begin
        edge_bit <= is_edge;
        edge_x   <= a22_x;
        edge_y   <= a22_y;
      end
    end
  end

  sobel_bbox_acc #(
    .CNT_W (CNT_W)
  ) u_acc (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (origin),
    .upd       (process && is_edge),
    .x         (a22_x),
    .y         (a22_y),
    .cnt_nxt   (acc_cnt),
    .x_min_nxt (acc_x_min),
    .x_max_nxt (acc_x_max),
    .y_min_nxt (acc_y_min),
    .y_max_nxt (acc_y_max)
  );

  // Result hand-off. A load always wins over an accept; overrun is flagged
  // only when the previous result was still pending and not taken this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat.stat_valid    <= 1'b0;
      stat.stat_overrun  <= 1'b0;
      stat.stat_edge_cnt <= '0;
      stat.stat_x_min    <= BBOX_EMPTY;
      stat.stat_x_max    <= '0;
      stat.stat_y_min    <= BBOX_EMPTY;
      stat.stat_y_max    <= '0;
    end else if (frame_done) begin
      stat.stat_valid    <= 1'b1;
      stat.stat_overrun  <= stat.stat_valid && !stat.stat_ready;
      stat.stat_edge_cnt <= acc_cnt;
      stat.stat_x_min    <= acc_x_min;
      stat.stat_x_max    <= acc_x_max;
      stat.stat_y_min    <= acc_y_min;
      stat.stat_y_max    <= acc_y_max;
    end else if (stat.stat_valid && stat.stat_ready) begin
      stat.stat_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sobel_edge_stats.sv
// tb_sobel_edge_stats: directed test of sobel_edge_stats on an 8x4 frame.
// A frame-level model (list of edge pixels per frame, min/max over the list
// at end of frame, pending-result bookkeeping) predicts every output; a
// negedge process compares DUT against it every cycle, and literal checks
// pin the model at key points.
module tb_sobel_edge_stats;
  import sobel_pkg::*;

  localparam int COL = 8;
  localparam int ROW = 4;
  localparam int MW  = 11;
  localparam int CW  = 22;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          in_valid = 1'b0, pos_valid = 1'b0;
  logic [11:0]   a22_x = '0, a22_y = '0;
  logic [MW-1:0] grad_mag = '0, threshold = '0;
  logic          edge_valid, edge_bit;
  logic [11:0]   edge_x, edge_y;

  sobel_edge_stats_if #(.CNT_W(CW)) sif ();

  sobel_edge_stats #(
    .RAW_FRAME_COLNUM (COL),
    .RAW_FRAME_ROWNUM (ROW),
    .MAG_W            (MW),
    .CNT_W            (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .pos_valid  (pos_valid),
    .a22_x      (a22_x),
    .a22_y      (a22_y),
    .grad_mag   (grad_mag),
    .threshold  (threshold),
    .edge_valid (edge_valid),
    .edge_bit   (edge_bit),
    .edge_x     (edge_x),
    .edge_y     (edge_y),
    .stat       (sif)
  );

  int n_assert = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Model state
  bit          m_in_frame;
  logic [10:0] m_thr;
  int          ex_q[$];
  int          ey_q[$];

  // Expected outputs after the most recent clock edge
  logic        exp_ev, exp_eb, exp_sv, exp_ovr;
  logic [11:0] exp_ex, exp_ey, exp_xmin, exp_xmax, exp_ymin, exp_ymax;
  logic [31:0] exp_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_assert++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_in_frame = 1'b0;
    m_thr      = '0;
    exp_ev = 0; exp_eb = 0; exp_ex = 0; exp_ey = 0;
    exp_sv = 0; exp_ovr = 0; exp_cnt = 0;
    exp_xmin = 12'hFFF; exp_xmax = 0; exp_ymin = 12'hFFF; exp_ymax = 0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("edge_valid", {31'b0, edge_valid}, {31'b0, exp_ev});
      chk("edge_bit",   {31'b0, edge_bit},   {31'b0, exp_eb});
      chk("edge_x",     {20'b0, edge_x},     {20'b0, exp_ex});
      chk("edge_y",     {20'b0, edge_y},     {20'b0, exp_ey});
      chk("stat_valid", {31'b0, sif.stat_valid}, {31'b0, exp_sv});
      chk("stat_overrun", {31'b0, sif.stat_overrun}, {31'b0, exp_ovr});
      chk("stat_edge_cnt", {10'b0, sif.stat_edge_cnt}, exp_cnt);
      chk("stat_x_min", {20'b0, sif.stat_x_min}, {20'b0, exp_xmin});
      chk("stat_x_max", {20'b0, sif.stat_x_max}, {20'b0, exp_xmax});
      chk("stat_y_min", {20'b0, sif.stat_y_min}, {20'b0, exp_ymin});
      chk("stat_y_max", {20'b0, sif.stat_y_max}, {20'b0, exp_ymax});
    end
  end

  // One clock cycle with the given inputs; called at posedge+1.
  task automatic step(input bit iv, input bit pv, input int x, input int y, input int mag);
    bit q, org, proc;
    logic        n_ev, n_eb, n_sv, n_ovr;
    logic [11:0] n_ex, n_ey, n_xmin, n_xmax, n_ymin, n_ymax;
    logic [31:0] n_cnt;
    in_valid = iv; pos_valid = pv;
    a22_x = 12'(x); a22_y = 12'(y); grad_mag = MW'(mag);

    n_ev = exp_ev; n_eb = exp_eb; n_ex = exp_ex; n_ey = exp_ey;
    n_sv = exp_sv; n_ovr = exp_ovr; n_cnt = exp_cnt;
    n_xmin = exp_xmin; n_xmax = exp_xmax; n_ymin = exp_ymin; n_ymax = exp_ymax;

    q    = iv && pv;
    org  = q && x == 0 && y == 0;
    proc = org || (m_in_frame && q);
    if (org) begin
      m_thr = threshold;
      ex_q.delete();
      ey_q.delete();
      m_in_frame = 1'b1;
    end
    n_ev = proc;
    if (proc) begin
      n_eb = (mag >= int'(m_thr));
      n_ex = 12'(x);
      n_ey = 12'(y);
      if (n_eb) begin
        ex_q.push_back(x);
        ey_q.push_back(y);
      end
    end
    if (proc && x == COL-1 && y == ROW-1) begin
      m_in_frame = 1'b0;
      n_ovr  = exp_sv && !sif.stat_ready;
      n_sv   = 1'b1;
      n_cnt  = 32'(ex_q.size());
      n_xmin = 12'hFFF; n_xmax = 0; n_ymin = 12'hFFF; n_ymax = 0;
      foreach (ex_q[i]) begin
        if (ex_q[i] < int'(n_xmin)) n_xmin = 12'(ex_q[i]);
        if (ex_q[i] > int'(n_xmax)) n_xmax = 12'(ex_q[i]);
        if (ey_q[i] < int'(n_ymin)) n_ymin = 12'(ey_q[i]);
        if (ey_q[i] > int'(n_ymax)) n_ymax = 12'(ey_q[i]);
      end
    end else if (exp_sv && sif.stat_ready) begin
      n_sv = 1'b0;
    end

    @(posedge clk);
    exp_ev = n_ev; exp_eb = n_eb; exp_ex = n_ex; exp_ey = n_ey;
    exp_sv = n_sv; exp_ovr = n_ovr; exp_cnt = n_cnt;
    exp_xmin = n_xmin; exp_xmax = n_xmax; exp_ymin = n_ymin; exp_ymax = n_ymax;
    #1;
  endtask

  function automatic int mag_of(input int pat, input int x, input int y);
    case (pat)
      0: return (x == 3 && y == 1) ? 200 : (x == 5 && y == 2) ? 300 : 0;
      1: return (x == 1 && y == 0) ? 500 : (x == 6 && y == 3) ? 150 :
                (x == 2 && y == 2) ? 90 : 0;
      default: return 'h7FF;
    endcase
  endfunction

  task automatic run_frame(input int pat, input bit gaps, input bit rdy_last,
                           input bit thr_sw, input logic [10:0] new_thr);
    for (int y = 0; y < ROW; y++) begin
      for (int x = 0; x < COL; x++) begin
        if (gaps) begin
          step(1'b0, 1'b1, x, y, 77);   // strobe low
          step(1'b1, 1'b0, 0, 0, 500);  // padding beat, even with origin coords
        end
        if (thr_sw && x == 2 && y == 1) threshold = new_thr;
        if (rdy_last && x == COL-1 && y == ROW-1) sif.stat_ready = 1'b1;
        step(1'b1, 1'b1, x, y, mag_of(pat, x, y));
      end
    end
    if (rdy_last) sif.stat_ready = 1'b0;
    in_valid = 1'b0;
    $display("frame pat=%0d gaps=%0d: stat_valid=%0d cnt=%0d x=%0d..%0d y=%0d..%0d overrun=%0d",
             pat, gaps, sif.stat_valid, sif.stat_edge_cnt, sif.stat_x_min,
             sif.stat_x_max, sif.stat_y_min, sif.stat_y_max, sif.stat_overrun);
  endtask

  task automatic accept();
    sif.stat_ready = 1'b1;
    step(1'b0, 1'b0, 0, 0, 0);
    sif.stat_ready = 1'b0;
  endtask

  task automatic chk_stats(input string tag, input int cnt, input int x0, input int x1,
                           input int y0, input int y1, input bit ovr);
    chk({tag, "_valid"}, {31'b0, sif.stat_valid}, 32'd1);
    chk({tag, "_cnt"},   {10'b0, sif.stat_edge_cnt}, 32'(cnt));
    chk({tag, "_xmin"},  {20'b0, sif.stat_x_min}, 32'(x0));
    chk({tag, "_xmax"},  {20'b0, sif.stat_x_max}, 32'(x1));
    chk({tag, "_ymin"},  {20'b0, sif.stat_y_min}, 32'(y0));
    chk({tag, "_ymax"},  {20'b0, sif.stat_y_max}, 32'(y1));
    chk({tag, "_ovr"},   {31'b0, sif.stat_overrun}, {31'b0, ovr});
  endtask

  initial begin
    sif.stat_ready = 1'b0;
    model_reset();
    #22 rst_n = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;

    // Reset state, literal
    chk("rst_stat_valid", {31'b0, sif.stat_valid}, 32'd0);
    chk("rst_x_min", {20'b0, sif.stat_x_min}, 32'hFFF);
    chk("rst_y_min", {20'b0, sif.stat_y_min}, 32'hFFF);
    chk("rst_edge_valid", {31'b0, edge_valid}, 32'd0);

    // 1: continuous frame
    threshold = 11'd100;
    run_frame(0, 1'b0, 1'b0, 1'b0, 11'd0);
    chk_stats("f1", 2, 3, 5, 1, 2, 1'b0);
    accept();
    chk("f1_accepted", {31'b0, sif.stat_valid}, 32'd0);
    chk("f1_edge_hold_x", {20'b0, edge_x}, 32'd7);

    // 2: gapped frame, threshold raised mid-frame (ignored until next origin)
    run_frame(0, 1'b1, 1'b0, 1'b1, 11'd1000);
    chk_stats("f2", 2, 3, 5, 1, 2, 1'b0);
    threshold = 11'd100;
    accept();

    // 3: two frames unread -> overrun
    run_frame(0, 1'b0, 1'b0, 1'b0, 11'd0);
    run_frame(1, 1'b0, 1'b0, 1'b0, 11'd0);
    chk_stats("f3", 2, 1, 6, 0, 3, 1'b1);
    accept();
    chk("f3_accepted", {31'b0, sif.stat_valid}, 32'd0);

    // 4: accept coincides with the new load
    run_frame(0, 1'b0, 1'b0, 1'b0, 11'd0);
    run_frame(1, 1'b0, 1'b1, 1'b0, 11'd0);
    step(1'b0, 1'b0, 0, 0, 0);
    chk_stats("f4", 2, 1, 6, 0, 3, 1'b0);
    accept();

    // 5: reset mid-frame at (4,2), then resync on next origin
    for (int i = 0; i < COL*ROW; i++) begin
      if (i == 2*COL + 4) begin
        rst_n = 1'b0;
        model_reset();
        #3 rst_n = 1'b1;
      end
      step(1'b1, 1'b1, i % COL, i / COL, mag_of(0, i % COL, i / COL));
    end
    step(1'b0, 1'b0, 0, 0, 0);
    chk("f5_no_result", {31'b0, sif.stat_valid}, 32'd0);
    chk("f5_no_edge", {31'b0, edge_valid}, 32'd0);
    run_frame(0, 1'b0, 1'b0, 1'b0, 11'd0);
    chk_stats("f5", 2, 3, 5, 1, 2, 1'b0);
    accept();

    // 6: every pixel an edge; threshold change mid-frame has no effect
    threshold = 11'd0;
    run_frame(2, 1'b0, 1'b0, 1'b1, 11'h7FF);
    chk_stats("f6", 32, 0, 7, 0, 3, 1'b0);
    accept();
    step(1'b0, 1'b0, 0, 0, 0);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sobel_edge_stats.md
Name: sobel_edge_stats

Overview:
Downstream consumer of the Sobel position stage. It takes the gradient magnitude together with the corrected position (a22_x/a22_y) and pos_valid, and produces a thresholded binary edge stream. It also accumulates per-frame edge statistics: the edge pixel count and the edge bounding box. At end of frame it presents those statistics on a valid/ready result port to the control/readout logic.

Parameters:
RAW_FRAME_COLNUM, 1920, active (unpadded) columns; x range 0..COLNUM-1
RAW_FRAME_ROWNUM, 1080, active rows; y range 0..ROWNUM-1
MAG_W, 11, gradient magnitude / threshold width
CNT_W, 22, edge count width; must hold COLNUM*ROWNUM

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  pixel beat strobe, aligned with the position stage's count_en
pos_valid  input  1  beat lies inside the active frame
a22_x  input  12  corrected column; meaningful only when pos_valid=1
a22_y  input  12  corrected row; meaningful only when pos_valid=1
grad_mag  input  MAG_W  gradient magnitude for this beat
threshold  input  MAG_W  edge threshold; quasi-static
edge_valid  output  1  registered qualified beat
edge_bit  output  1  1 = edge (grad_mag >= latched threshold)
edge_x  output  12  x of the edge_bit beat
edge_y  output  12  y of the edge_bit beat
stat_valid  output  1  frame statistics available
stat_ready  input  1  consumer accepts statistics
stat_edge_cnt  output  CNT_W  edge pixels in frame
stat_x_min  output  12  bounding box left
stat_x_max  output  12  bounding box right
stat_y_min  output  12  bounding box top
stat_y_max  output  12  bounding box bottom
stat_overrun  output  1  previous result was overwritten unread

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values: all outputs are 0, except stat_x_min and stat_y_min, which reset to 12'hFFF. State is IDLE. Accumulators hold their empty values.
- Qualified beat: qbeat = in_valid && pos_valid. Beats that are not qualified change nothing.
- Origin beat: qbeat with a22_x==0 and a22_y==0.
- Last beat: qbeat with a22_x==COLNUM-1 and a22_y==ROWNUM-1.
- FSM IDLE: ignore all qbeats except the origin beat. On the origin beat:
  - latch threshold into thr_q;
  - clear accumulators (count=0, x_min=y_min=FFF, x_max=y_max=0) and then apply this beat;
  - go to ACCUM.
  - Edge output is also suppressed in IDLE except for the origin beat. This gives frame resync after reset mid-frame.
- FSM ACCUM: every qbeat is processed. On the last beat, process it, then go to IDLE.
- Origin beat while in ACCUM (truncated frame): restart the accumulation as in IDLE. No result is produced for the truncated frame.
- Edge path, 1-cycle latency:
  - edge_valid is the registered qbeat value (gated by FSM as above);
  - edge_bit = (grad_mag >= thr_q); on the origin beat the comparison uses the live threshold input;
  - edge_x/edge_y are registered a22_x/a22_y;
  - edge_x/edge_y/edge_bit hold their values when edge_valid=0.
- Accumulate on an edge beat:
  - count += 1, saturating at all-ones;
  - x_min = min(x_min, x), x_max = max(x_max, x), same for y.
- Result hand-off:
  - The cycle after the last beat, the stat_* registers load the final accumulators (including the last beat) and stat_valid goes to 1.
  - stat_valid holds until a cycle with stat_valid && stat_ready, then it clears.
  - The stat_* data stays stable while stat_valid=1, unless an overwrite occurs.
- Overwrite rules:
  - A new result arrives while stat_valid=1 and stat_ready=0: overwrite the data, stat_valid stays 1, stat_overrun=1.
  - A new result load coincides with an accept: treat as a normal load; stat_valid stays 1, stat_overrun=0.
  - stat_overrun is part of the result; it clears on the next normal load.
- Empty frame (no edges): count=0, x_min/y_min=FFF, x_max/y_max=0. The consumer detects this via count==0.
- Threshold changes mid-frame have no effect until the next origin beat.

Decomposition:
- Shared package sobel_pkg: RAW_FRAME_COLNUM/ROWNUM defaults, 12-bit coordinate width constant, MAG_W, CNT_W, FSM state enum {IDLE, ACCUM}, empty-bbox constant 12'hFFF.
- One natural sub-module: sobel_bbox_acc, holding the count, min/max registers with clear/update/saturate logic. The top keeps the FSM, edge pipeline and result hand-off.

Test Plan:
All scenarios use COLNUM=8, ROWNUM=4, MAG_W=11.
- Full frame, in_valid continuous, grad_mag=0 except (3,1)=200 and (5,2)=300, threshold=100 -> edge_bit=1 at exactly those two edge_x/edge_y one cycle later; stat_valid rises the cycle after beat (7,3); count=2, bbox x 3..5, y 1..2.
- Same frame with in_valid toggling every other cycle and pos_valid=0 padding beats interleaved -> identical statistics; no edge_valid on non-qualified beats.
- Two frames with stat_ready=0 throughout -> after frame 2, stat_valid=1, data equals frame 2, stat_overrun=1. Then stat_ready=1 for one cycle -> stat_valid=0.
- Assert stat_ready exactly in the cycle frame 2's result loads -> stat_valid stays 1, stat_overrun=0, data equals frame 2.
- Pulse rst_n low mid-frame at (4,2), release, continue the stream -> no edge_valid and no result until the next (0,0); the following full frame yields correct statistics.
- All grad_mag=0x7FF, threshold=0 -> count=32, bbox 0..7 / 0..3. Threshold changed to 0x7FF at (2,1) -> no effect, count still 32.
